mc1_fn: RTL and testbench
=========================

Name: mc1_fn

Overview:
- Registered evaluator for the 4-input Boolean function F(A,B,C,D) = ΠM(0,1,2,8,10,12,14), with A as the MSB.
- Adds an input-coverage monitor: a 16-bit mask of the minterms applied so far, plus counters.
- Used as a self-checking function unit in the CSARCH combinational-logic exercise datapath.

Parameters:
- CNT_W, 8, width of the evaluation and ones counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  sample abcd this cycle
- abcd  input  4  {A,B,C,D}; abcd[3]=A, abcd[0]=D
- cov_clr  input  1  synchronous clear of coverage mask and counters
- out_valid  output  1  f valid this cycle
- f  output  1  registered function value
- cov_mask  output  16  bit i set once minterm i has been evaluated
- cov_done  output  1  cov_mask == 16'hFFFF
- eval_cnt  output  CNT_W  number of accepted evaluations (saturating)
- ones_cnt  output  CNT_W  number of accepted evaluations with F=1 (saturating)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Function: F=0 for minterms 0,1,2,8,10,12,14; F=1 for minterms 3,4,5,6,7,9,11,13,15.
- Gate-level POS form: F = (B+D)(A'+D)(A+B+C+D').
- Equivalent SOP: F = D(A+B+C) + A'B.
- Reset: while rst is high, f=0, out_valid=0, cov_mask=0, eval_cnt=0, ones_cnt=0, cov_done=0. Takes effect immediately, independent of clk.
- Latency: 1 cycle. If in_valid is high at edge k, then at edge k+1 out_valid=1 and f=F(abcd sampled at k). If in_valid is low, out_valid=0 next cycle and f holds its last value.
- Back-to-back in_valid is accepted every cycle. There is no backpressure.
- Coverage: on an accepted sample, set cov_mask[abcd] and increment eval_cnt. Also increment ones_cnt if F=1. The mask updates in the same cycle that f registers.
- cov_done is combinational from cov_mask.
- Saturation: each counter holds at all-ones and never wraps.
- cov_clr with no in_valid in the same cycle: mask and counters go to 0 next cycle. f and out_valid are unaffected.
- cov_clr together with in_valid: the clear is applied first, then the new sample is recorded. Next cycle, cov_mask has only that one bit set, eval_cnt=1, and ones_cnt=F.
- Reset asserted mid-stream: all state clears immediately. The first accepted sample after deassertion behaves as from power-up.
- X on abcd while in_valid is low must not propagate into any register.

Optional Feature:
- Macro MC1_SOP_CHECK_EN.
- Defined: add a parallel SOP implementation and a registered output mism (1 bit). mism is set sticky when out_valid=1 and the POS result differs from the SOP result. It is cleared by rst or cov_clr.
- Undefined: the port is absent and there is no SOP logic. All other behaviour is identical.

Decomposition:
- Shared package mc1_pkg:
  - localparam MAXTERM_MASK = 16'b0101_0101_0000_0111 (bit i = 1 means minterm i is a maxterm of F, i.e. F=0; set bits 0,1,2,8,10,12,14).
  - localparam ONES_MASK = ~MAXTERM_MASK.
  - default CNT_W.
- One sub-module, mc1_gates: purely combinational, gate-level POS from primitive and/or/not gates, with inputs A,B,C,D and output F. Instantiated once. The optional SOP checker is inline in the top level.

Test Plan:
- Reset then sweep abcd = 0..15 with in_valid=1 every cycle -> f sequence 0,0,0,1,1,1,1,1,0,1,0,1,0,1,0,1 starting one cycle later; cov_done=1 after the 16th; eval_cnt=16; ones_cnt=9.
- Apply abcd=4'b1100 then 4'b0100 -> f=0 then f=1; cov_mask=16'h1010.
- in_valid=0 with abcd=X for 5 cycles after a sample giving f=1 -> out_valid=0 and f stays 1; counters unchanged.
- cov_clr=1 together with in_valid and abcd=4'b0011 after a full sweep -> next cycle cov_mask=16'h0008, eval_cnt=1, ones_cnt=1, cov_done=0.
- Assert rst asynchronously mid-sweep (between edges) -> f, out_valid, cov_mask and counters are 0 before the next edge.
- With CNT_W=2, apply 5 samples of abcd=4'b1111 -> eval_cnt=3 and ones_cnt=3 (saturated). With MC1_SOP_CHECK_EN defined, mism stays 0 throughout the full sweep.

Source files
------------

// File: rtl/mc1_pkg.sv
// Shared constants for the mc1_fn function unit.
// F(A,B,C,D) = PI M(0,1,2,8,10,12,14), A is the MSB of the minterm index.
package mc1_pkg;
    // Bit i set means minterm i is a maxterm (F=0).
    localparam logic [15:0] MAXTERM_MASK  = 16'b0101_0101_0000_0111;
    localparam logic [15:0] ONES_MASK     = ~MAXTERM_MASK;
    localparam int          CNT_W_DEFAULT = 8;

    // One-hot coverage bit for a minterm index.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction
endpackage

// File: rtl/mc1_fn_if.sv
// Sample/result bundle for mc1_fn. The mism signal exists only when
// MC1_SOP_CHECK_EN is defined.
interface mc1_fn_if #(parameter int CNT_W = mc1_pkg::CNT_W_DEFAULT);
    logic             in_valid;
    logic [3:0]       abcd;
    logic             cov_clr;
    logic             out_valid;
    logic             f;
    logic [15:0]      cov_mask;
    logic             cov_done;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] ones_cnt;
`ifdef MC1_SOP_CHECK_EN
    logic             mism;
`endif

    modport master (
        output in_valid, abcd, cov_clr,
        input  out_valid, f, cov_mask, cov_done, eval_cnt, ones_cnt
`ifdef MC1_SOP_CHECK_EN
        , input mism
`endif
    );

    modport slave (
        input  in_valid, abcd, cov_clr,
        output out_valid, f, cov_mask, cov_done, eval_cnt, ones_cnt
`ifdef MC1_SOP_CHECK_EN
        , output mism
`endif
    );
endinterface

// File: rtl/mc1_gates.sv
// Gate-level POS form of F: F = (B+D)(A'+D)(A+B+C+D').
module mc1_gates (
    input  wire a_i,
    input  wire b_i,
    input  wire c_i,
    input  wire d_i,
    output wire f_o
);
    wire na, nd, s0, s1, s2;

    not u_na (na, a_i);
    not u_nd (nd, d_i);
    or  u_s0 (s0, b_i, d_i);
    or  u_s1 (s1, na, d_i);
    or  u_s2 (s2, a_i, b_i, c_i, nd);
    and u_f  (f_o, s0, s1, s2);
endmodule

// File: rtl/mc1_fn.sv
// Registered evaluator of F plus input-coverage monitor (mask + saturating
// eval/ones counters). Optional macro MC1_SOP_CHECK_EN adds a parallel SOP
// evaluation and a sticky POS/SOP mismatch flag.
module mc1_fn
    import mc1_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    mc1_fn_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             f_q, f_d;
    logic             vld_q, vld_d;
    logic [15:0]      mask_q, mask_d;
    logic [CNT_W-1:0] eval_q, eval_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [15:0]      mask_base;
    logic [CNT_W-1:0] eval_base, ones_base;
    logic [3:0]       abcd_g;
    wire              f_pos;

    // Gating with in_valid keeps an undriven/X sample out of the datapath.
    assign abcd_g = bus.abcd & {4{bus.in_valid}};

    mc1_gates u_gates (
        .a_i (abcd_g[3]),
        .b_i (abcd_g[2]),
        .c_i (abcd_g[1]),
        .d_i (abcd_g[0]),
        .f_o (f_pos)
    );

    // Next state: clear first, then record the accepted sample.
    always_comb begin
        mask_base = bus.cov_clr ? 16'h0000 : mask_q;
        eval_base = bus.cov_clr ? '0 : eval_q;
        ones_base = bus.cov_clr ? '0 : ones_q;
        vld_d     = bus.in_valid;
        f_d       = f_q;
        mask_d    = mask_base;
        eval_d    = eval_base;
        ones_d    = ones_base;
        if (bus.in_valid) begin
            f_d    = f_pos;
            mask_d = mask_base | onehot16(abcd_g);
            if (eval_base != CNT_MAX) eval_d = eval_base + 1'b1;
            if (f_pos && (ones_base != CNT_MAX)) ones_d = ones_base + 1'b1;
        end
    end

    // State registers, async active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= 1'b0;
            vld_q  <= 1'b0;
            mask_q <= 16'h0000;
            eval_q <= '0;
            ones_q <= '0;
        end else begin
            f_q    <= f_d;
            vld_q  <= vld_d;
            mask_q <= mask_d;
            eval_q <= eval_d;
            ones_q <= ones_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.f         = f_q;
    assign bus.cov_mask  = mask_q;
    assign bus.cov_done  = &mask_q;
    assign bus.eval_cnt  = eval_q;
    assign bus.ones_cnt  = ones_q;

`ifdef MC1_SOP_CHECK_EN
    logic mism_q, mism_d;
    logic f_sop;

    // SOP form: F = D(A+B+C) + A'B, evaluated on the same gated sample.
    assign f_sop = (abcd_g[0] & (abcd_g[3] | abcd_g[2] | abcd_g[1])) |
                   (~abcd_g[3] & abcd_g[2]);

    // Mismatch is captured with the sample so it shows up with out_valid.
    always_comb begin
        mism_d = (bus.cov_clr ? 1'b0 : mism_q) |
                 (bus.in_valid & (f_pos ^ f_sop));
    end

    // Sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mism_q <= 1'b0;
        else     mism_q <= mism_d;
    end

    assign bus.mism = mism_q;
`endif
endmodule

// File: tb/tb_mc1_fn.sv
// Directed bench for mc1_fn: a default-width instance and a CNT_W=2 instance
// see identical stimulus; a minterm-list model is compared every cycle and
// hand-computed literals pin the model at key points.
module tb_mc1_fn;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mc1_fn_if #(.CNT_W(8)) b1 ();
    mc1_fn_if #(.CNT_W(2)) b2 ();

    assign b2.in_valid = b1.in_valid;
    assign b2.abcd     = b1.abcd;
    assign b2.cov_clr  = b1.cov_clr;

    mc1_fn #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(b1.slave));
    mc1_fn #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // F straight from the maxterm list.
    function automatic logic fref(input logic [3:0] m);
        case (m)
            4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Model: true (unsaturated) counts, saturation applied at compare time.
    logic        mvld, mf;
    logic [15:0] mmask;
    int          mev, mon;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mvld <= 1'b0; mf <= 1'b0; mmask <= 16'h0; mev <= 0; mon <= 0;
        end else begin
            mvld  <= b1.in_valid;
            if (b1.in_valid) mf <= fref(b1.abcd);
            mmask <= (b1.cov_clr ? 16'h0 : mmask) |
                     (b1.in_valid ? (16'h1 << b1.abcd) : 16'h0);
            mev   <= (b1.cov_clr ? 0 : mev) + (b1.in_valid ? 1 : 0);
            mon   <= (b1.cov_clr ? 0 : mon) + ((b1.in_valid && fref(b1.abcd)) ? 1 : 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_vld",   b1.out_valid, mvld);
        chk("m_f",     b1.f,         mf);
        chk("m_mask",  b1.cov_mask,  mmask);
        chk("m_done",  b1.cov_done,  (mmask == 16'hFFFF));
        chk("m_eval",  b1.eval_cnt,  sat(mev, 255));
        chk("m_ones",  b1.ones_cnt,  sat(mon, 255));
        chk("s_f",     b2.f,         mf);
        chk("s_eval",  b2.eval_cnt,  sat(mev, 3));
        chk("s_ones",  b2.ones_cnt,  sat(mon, 3));
`ifdef MC1_SOP_CHECK_EN
        chk("m_mism",  b1.mism,      1'b0);
`endif
    end

    task automatic step(input logic v, input logic [3:0] a, input logic clr);
        b1.in_valid = v;
        b1.abcd     = a;
        b1.cov_clr  = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        seq = 16'hAAF8;   // f for minterms 15..0
        rst = 1'b1;
        b1.in_valid = 1'b0; b1.abcd = 4'h0; b1.cov_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_f",    b1.f,         0);
        chk("rst_vld",  b1.out_valid, 0);
        chk("rst_mask", b1.cov_mask,  0);
        chk("rst_eval", b1.eval_cnt,  0);
        chk("rst_done", b1.cov_done,  0);
        rst = 1'b0;

        // Full sweep.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0);
            chk("sweep_f",   b1.f,         seq[i]);
            chk("sweep_vld", b1.out_valid, 1);
        end
        chk("sweep_done", b1.cov_done, 1);
        chk("sweep_mask", b1.cov_mask, 16'hFFFF);
        chk("sweep_eval", b1.eval_cnt, 16);
        chk("sweep_ones", b1.ones_cnt, 9);
        chk("sweep_seval", b2.eval_cnt, 3);
        chk("sweep_sones", b2.ones_cnt, 3);

        // Clear together with a sample.
        step(1'b1, 4'b0011, 1'b1);
        chk("clrv_mask", b1.cov_mask, 16'h0008);
        chk("clrv_eval", b1.eval_cnt, 1);
        chk("clrv_ones", b1.ones_cnt, 1);
        chk("clrv_done", b1.cov_done, 0);

        // 1100 then 0100.
        step(1'b1, 4'b1100, 1'b1);
        chk("p12_f", b1.f, 0);
        step(1'b1, 4'b0100, 1'b0);
        chk("p4_f",    b1.f,        1);
        chk("p4_mask", b1.cov_mask, 16'h1010);

        // Idle with X on abcd.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'bxxxx, 1'b0);
            chk("idle_vld",  b1.out_valid, 0);
            chk("idle_f",    b1.f,         1);
            chk("idle_eval", b1.eval_cnt,  2);
            chk("idle_ones", b1.ones_cnt,  1);
            chk("idle_mask", b1.cov_mask,  16'h1010);
        end

        // Clear alone.
        step(1'b0, 4'h0, 1'b1);
        chk("clr_mask", b1.cov_mask,  0);
        chk("clr_eval", b1.eval_cnt,  0);
        chk("clr_f",    b1.f,         1);
        chk("clr_vld",  b1.out_valid, 0);

        // Saturation on the narrow instance.
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 1'b0);
        chk("satm_eval", b1.eval_cnt, 5);
        chk("satm_ones", b1.ones_cnt, 5);
        chk("sat_eval",  b2.eval_cnt, 3);
        chk("sat_ones",  b2.ones_cnt, 3);

        // Async reset mid-sweep.
        for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 1'b0);
        b1.abcd = 4'd6;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_f",    b1.f,         0);
        chk("arst_vld",  b1.out_valid, 0);
        chk("arst_mask", b1.cov_mask,  0);
        chk("arst_eval", b1.eval_cnt,  0);
        chk("arst_ones", b1.ones_cnt,  0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'd5, 1'b0);
        chk("post_f",    b1.f,        1);
        chk("post_mask", b1.cov_mask, 16'h0020);
        chk("post_eval", b1.eval_cnt, 1);
        chk("post_ones", b1.ones_cnt, 1);

        step(1'b0, 4'h0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
